// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, select codes and state encoding for the multi-cycle MIPS controller
package mips_pkg;

   localparam int OP_W = 6;
   localparam int ST_W = 4;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [ST_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11
   } state_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_BNE) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath signal bundle
interface multicycle_control_if;
   import mips_pkg::*;

   logic [OP_W-1:0] opcode;
   logic            mem_ready;
   logic            PC_write;
   logic            PC_write_beq;
   logic            PC_write_bne;
   logic            IorD;
   logic            mem_read;
   logic            mem_write;
   logic            IR_write;
   logic            mem_to_reg;
   logic            reg_dst;
   logic            reg_write;
   logic            ALU_src_A;
   logic [1:0]      ALU_src_B;
   logic [1:0]      ALU_op;
   logic [1:0]      PC_source;
   logic            instr_done;
   logic            illegal_op;

   modport master (
      input  opcode, mem_ready,
      output PC_write, PC_write_beq, PC_write_bne, IorD, mem_read, mem_write, IR_write,
             mem_to_reg, reg_dst, reg_write, ALU_src_A, ALU_src_B, ALU_op, PC_source,
             instr_done, illegal_op
   );

   modport slave (
      output opcode, mem_ready,
      input  PC_write, PC_write_beq, PC_write_bne, IorD, mem_read, mem_write, IR_write,
             mem_to_reg, reg_dst, reg_write, ALU_src_A, ALU_src_B, ALU_op, PC_source,
             instr_done, illegal_op
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main controller FSM
module multicycle_control
   import mips_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   multicycle_control_if.master bus
);

   state_t          state;
   state_t          state_next;
   logic [OP_W-1:0] op_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
         op_q  <= '0;
      end else begin
         state <= state_next;
         if (state == S_DECODE) begin
            op_q <= bus.opcode;
         end
      end
   end

   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:    state_next = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:      state_next = S_EXEC;
               OP_LW, OP_SW:  state_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_next = S_BRANCH;
               OP_J:          state_next = S_JUMP;
               OP_ADDI:       state_next = S_ADDI_EX;
               default:       state_next = S_FETCH;
            endcase
         end
         S_MEM_ADDR: state_next = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_next = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   state_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
         S_EXEC:     state_next = S_R_WB;
         S_ADDI_EX:  state_next = S_ADDI_WB;
         default:    state_next = S_FETCH;
      endcase
   end

   // Outputs are held at zero for the whole time rst is high, not just after the edge.
   always_comb begin
      bus.PC_write     = 1'b0;
      bus.PC_write_beq = 1'b0;
      bus.PC_write_bne = 1'b0;
      bus.IorD         = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.IR_write     = 1'b0;
      bus.mem_to_reg   = 1'b0;
      bus.reg_dst      = 1'b0;
      bus.reg_write    = 1'b0;
      bus.ALU_src_A    = 1'b0;
      bus.ALU_src_B    = SRCB_REGB;
      bus.ALU_op       = ALUOP_ADD;
      bus.PC_source    = PCSRC_ALU;
      bus.instr_done   = 1'b0;
      bus.illegal_op   = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               bus.mem_read  = 1'b1;
               bus.ALU_src_B = SRCB_FOUR;
               bus.IR_write  = bus.mem_ready;
               bus.PC_write  = bus.mem_ready;
            end
            S_DECODE: begin
               bus.ALU_src_B  = SRCB_IMM_SH2;
               bus.illegal_op = !is_legal_op(bus.opcode);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
               bus.ALU_src_A = 1'b1;
               bus.ALU_src_B = SRCB_IMM;
            end
            S_MEM_RD: begin
               bus.mem_read = 1'b1;
               bus.IorD     = 1'b1;
            end
            S_MEM_WB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
               bus.instr_done = 1'b1;
            end
            S_MEM_WR: begin
               bus.mem_write  = 1'b1;
               bus.IorD       = 1'b1;
               bus.instr_done = bus.mem_ready;
            end
            S_EXEC: begin
               bus.ALU_src_A = 1'b1;
               bus.ALU_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
               bus.reg_write  = 1'b1;
               bus.reg_dst    = 1'b1;
               bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
               bus.ALU_src_A    = 1'b1;
               bus.ALU_op       = ALUOP_SUB;
               bus.PC_source    = PCSRC_ALUOUT;
               bus.PC_write_beq = (op_q == OP_BEQ);
               bus.PC_write_bne = (op_q == OP_BNE);
               bus.instr_done   = 1'b1;
            end
            S_JUMP: begin
               bus.PC_write   = 1'b1;
               bus.PC_source  = PCSRC_JUMP;
               bus.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
               bus.reg_write  = 1'b1;
               bus.instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
